bf_program_loader: RTL and testbench
====================================

BF_PROGRAM_LOADER -- requirements
Module: bf_program_loader

Interface
REQ-001 SHALL have parameter PRGMEM_ADDR_WIDTH, default 8, program memory address width; capacity is 2^PRGMEM_ADDR_WIDTH instructions.
REQ-002 SHALL have parameter MAX_NEST, default 16, maximum open '[' depth accepted; it matches the 4-bit loop stack.
REQ-003 SHALL have port i_clock  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port i_reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port i_start  input  1  single-cycle load request.
REQ-006 SHALL have port i_valid  input  1  source byte valid.
REQ-007 SHALL have port i_data  input  8  ASCII source byte.
REQ-008 SHALL have port o_ready  output  1  loader accepts i_data this cycle.
REQ-009 SHALL have port o_prgmem_in  output  1  program memory write strobe.
REQ-010 SHALL have port o_prgmem_addr  output  PRGMEM_ADDR_WIDTH  write address.
REQ-011 SHALL have port o_prgmem_data  output  3  encoded instruction.
REQ-012 SHALL have ports o_busy, o_done  output  1 each  loading in progress; load completed cleanly.
REQ-013 SHALL have port o_error  output  2  0 none, 1 unmatched ']', 2 unclosed '[' at end, 3 capacity exceeded.
REQ-014 SHALL have port o_length  output  PRGMEM_ADDR_WIDTH+1  number of commands written.

Function
REQ-015 SHALL encode '+'=011, '-'=010, '>'=101, '<'=100, '['=111, ']'=110; bit0 set for + > [; bits[2:1] 01 tape, 10 pointer, 11 loop.
REQ-016 SHALL encode fill/end slots as 000.
REQ-017 SHALL discard every other byte value except 0x00, including '.', ',' and whitespace, with no write and no counter change.
REQ-018 SHALL implement states IDLE, LOAD, FILL, DONE, ERROR.
REQ-019 SHALL move from IDLE, DONE or ERROR to LOAD on i_start, clearing address counter, depth, o_length, o_done and o_error; i_start in LOAD/FILL is ignored.
REQ-020 SHALL assert o_ready combinationally only in LOAD and only when no capacity or nesting error is pending; a byte transfers when i_valid and o_ready are both high at a rising edge.
REQ-021 SHALL register writes: a command accepted at edge N drives o_prgmem_in=1 with its address and code for exactly the cycle after N; accepting a command every cycle gives one write per cycle.
REQ-022 SHALL increment the address counter and o_length per written command; '[' increments depth, ']' decrements it.
REQ-023 SHALL on ']' at depth 0 write nothing and go to ERROR, code 1.
REQ-024 SHALL on '[' at depth MAX_NEST write nothing and go to ERROR, code 3.
REQ-025 SHALL on a command when o_length equals 2^PRGMEM_ADDR_WIDTH write nothing and go to ERROR, code 3; exactly 256 commands is legal.
REQ-026 SHALL on 0x00 go to ERROR, code 2, if depth is nonzero; otherwise go to FILL.
REQ-027 SHALL in FILL write 000 to each address from o_length up to the last address, one per cycle, then enter DONE; a full program enters DONE the cycle after the terminator with no fill writes.
REQ-028 SHALL hold o_busy high in LOAD and FILL; o_done high only in DONE; o_error nonzero only in ERROR; ERROR and DONE are held until i_start or i_reset.

Reset
REQ-029 SHALL on i_reset high at an edge enter IDLE and zero every output and counter, including mid-LOAD and mid-FILL; o_prgmem_in is 0 the cycle after that edge.
REQ-030 SHALL give reset priority over i_start and i_valid in the same cycle.

Verification
REQ-031 SHALL cover "+[->+<]" then 0x00 -> writes 011,111,010,101,011,100,110 at 0..6, then 000 at 7..255, then o_done=1 and o_length=7.
REQ-032 SHALL cover "a+ .\n-" then 0x00 -> only 011@0 and 010@1 are written, o_length=2.
REQ-033 SHALL cover "]" -> no write, o_error=1, o_ready=0; "[[" then 0x00 -> o_error=2 after 2 writes.
REQ-034 SHALL cover 17 '[' -> 16 writes, o_error=3; 256 '+' then 0x00 -> DONE with no fill; a 257th '+' -> o_error=3.
REQ-035 SHALL cover i_reset asserted during FILL at address 100 -> next cycle IDLE, o_prgmem_in=0, o_busy=0; a new i_start restarts from address 0.
REQ-036 SHALL cover random i_valid gaps -> identical write sequence to the gap-free run.

Source files
------------

// File: rtl/bf_program_loader_if.sv
`default_nettype none
// ============================================================================
// Module   : bf_program_loader_if
// Brief    : Source-byte handshake and program-memory write bus for the
//            Brainfuck program loader, plus its status outputs.
// Revision : 1.0  initial release
// ============================================================================
interface bf_program_loader_if #(
  parameter int PRGMEM_ADDR_WIDTH = 8
);
  logic                         i_start;
  logic                         i_valid;
  logic [7:0]                   i_data;
  logic                         o_ready;
  logic                         o_prgmem_in;
  logic [PRGMEM_ADDR_WIDTH-1:0] o_prgmem_addr;
  logic [2:0]                   o_prgmem_data;
  logic                         o_busy;
  logic                         o_done;
  logic [1:0]                   o_error;
  logic [PRGMEM_ADDR_WIDTH:0]   o_length;

  // Byte source / controller side
  modport master (
    output i_start, i_valid, i_data,
    input  o_ready, o_prgmem_in, o_prgmem_addr, o_prgmem_data,
    input  o_busy, o_done, o_error, o_length
  );

  // Loader side
  modport slave (
    input  i_start, i_valid, i_data,
    output o_ready, o_prgmem_in, o_prgmem_addr, o_prgmem_data,
    output o_busy, o_done, o_error, o_length
  );
endinterface
`default_nettype wire

// File: rtl/bf_program_loader.sv
`default_nettype none
// ============================================================================
// Module   : bf_program_loader
// Brief    : Accepts ASCII Brainfuck source, encodes the six tape/pointer/loop
//            commands into 3-bit codes, writes them to program memory, checks
//            bracket balance and capacity, and zero-fills the unused tail.
// Revision : 1.0  initial release
// ============================================================================
module bf_program_loader #(
  parameter int PRGMEM_ADDR_WIDTH = 8,
  parameter int MAX_NEST          = 16
) (
  input  wire logic            i_clock,
  input  wire logic            i_reset,
  bf_program_loader_if.slave   bus
);

  localparam int c_DEPTH_W = $clog2(MAX_NEST + 1);
  localparam int c_LEN_W   = PRGMEM_ADDR_WIDTH + 1;

  localparam logic [c_LEN_W-1:0]   c_CAPACITY  = {1'b1, {PRGMEM_ADDR_WIDTH{1'b0}}};
  localparam logic [c_LEN_W-1:0]   c_LAST_ADDR = {1'b0, {PRGMEM_ADDR_WIDTH{1'b1}}};
  localparam logic [c_LEN_W-1:0]   c_LEN_ONE   = c_LEN_W'(1);
  localparam logic [c_DEPTH_W-1:0] c_DEPTH_ONE = c_DEPTH_W'(1);
  localparam logic [c_DEPTH_W-1:0] c_MAX_NEST  = c_DEPTH_W'(MAX_NEST);

  localparam logic [2:0] c_CODE_OPEN  = 3'b111;
  localparam logic [2:0] c_CODE_CLOSE = 3'b110;

  localparam logic [1:0] c_ERR_NONE     = 2'd0;
  localparam logic [1:0] c_ERR_UNMATCH  = 2'd1;
  localparam logic [1:0] c_ERR_UNCLOSED = 2'd2;
  localparam logic [1:0] c_ERR_CAPACITY = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_FILL  = 3'd2,
    S_DONE  = 3'd3,
    S_ERROR = 3'd4
  } state_t;

  state_t                       r_state,     w_state;
  logic [c_LEN_W-1:0]           r_length,    w_length;
  logic [c_LEN_W-1:0]           r_fill_addr, w_fill_addr;
  logic [c_DEPTH_W-1:0]         r_depth,     w_depth;
  logic [1:0]                   r_error,     w_error;
  logic                         r_wr_en,     w_wr_en;
  logic [PRGMEM_ADDR_WIDTH-1:0] r_wr_addr,   w_wr_addr;
  logic [2:0]                   r_wr_data,   w_wr_data;

  logic       w_is_cmd;
  logic [2:0] w_code;

  // Map the incoming ASCII byte onto its instruction code; anything else is not a command
  always_comb begin
    w_is_cmd = 1'b1;
    w_code   = 3'b000;
    case (bus.i_data)
      8'h2B:   w_code = 3'b011;  // '+'
      8'h2D:   w_code = 3'b010;  // '-'
      8'h3E:   w_code = 3'b101;  // '>'
      8'h3C:   w_code = 3'b100;  // '<'
      8'h5B:   w_code = 3'b111;  // '['
      8'h5D:   w_code = 3'b110;  // ']'
      default: w_is_cmd = 1'b0;
    endcase
  end

  // Next-state, counter and write-port logic
  always_comb begin
    w_state     = r_state;
    w_length    = r_length;
    w_fill_addr = r_fill_addr;
    w_depth     = r_depth;
    w_error     = r_error;
    w_wr_en     = 1'b0;
    w_wr_addr   = r_wr_addr;
    w_wr_data   = r_wr_data;

    case (r_state)
      S_IDLE, S_DONE, S_ERROR: begin
        if (bus.i_start) begin
          w_state     = S_LOAD;
          w_length    = '0;
          w_fill_addr = '0;
          w_depth     = '0;
          w_error     = c_ERR_NONE;
        end
      end

      S_LOAD: begin
        // o_ready is high throughout LOAD, so i_valid alone means a transfer
        if (bus.i_valid) begin
          if (bus.i_data == 8'h00) begin
            if (r_depth != '0) begin
              w_state = S_ERROR;
              w_error = c_ERR_UNCLOSED;
            end else if (r_length == c_CAPACITY) begin
              // Memory already full: nothing left to pad
              w_state = S_DONE;
            end else begin
              w_state     = S_FILL;
              w_fill_addr = r_length;
            end
          end else if (w_is_cmd) begin
            if (w_code == c_CODE_CLOSE && r_depth == '0) begin
              w_state = S_ERROR;
              w_error = c_ERR_UNMATCH;
            end else if (w_code == c_CODE_OPEN && r_depth == c_MAX_NEST) begin
              w_state = S_ERROR;
              w_error = c_ERR_CAPACITY;
            end else if (r_length == c_CAPACITY) begin
              w_state = S_ERROR;
              w_error = c_ERR_CAPACITY;
            end else begin
              w_wr_en   = 1'b1;
              w_wr_addr = r_length[PRGMEM_ADDR_WIDTH-1:0];
              w_wr_data = w_code;
              w_length  = r_length + c_LEN_ONE;
              if (w_code == c_CODE_OPEN) begin
                w_depth = r_depth + c_DEPTH_ONE;
              end else if (w_code == c_CODE_CLOSE) begin
                w_depth = r_depth - c_DEPTH_ONE;
              end
            end
          end
        end
      end

      S_FILL: begin
        w_wr_en   = 1'b1;
        w_wr_addr = r_fill_addr[PRGMEM_ADDR_WIDTH-1:0];
        w_wr_data = 3'b000;
        if (r_fill_addr == c_LAST_ADDR) begin
          w_state = S_DONE;
        end else begin
          w_fill_addr = r_fill_addr + c_LEN_ONE;
        end
      end

      default: w_state = S_IDLE;
    endcase
  end

  // State and datapath registers; reset wins over every other input
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_length    <= '0;
      r_fill_addr <= '0;
      r_depth     <= '0;
      r_error     <= c_ERR_NONE;
      r_wr_en     <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= 3'b000;
    end else begin
      r_state     <= w_state;
      r_length    <= w_length;
      r_fill_addr <= w_fill_addr;
      r_depth     <= w_depth;
      r_error     <= w_error;
      r_wr_en     <= w_wr_en;
      r_wr_addr   <= w_wr_addr;
      r_wr_data   <= w_wr_data;
    end
  end

  assign bus.o_ready       = (r_state == S_LOAD);
  assign bus.o_busy        = (r_state == S_LOAD) || (r_state == S_FILL);
  assign bus.o_done        = (r_state == S_DONE);
  assign bus.o_error       = r_error;
  assign bus.o_length      = r_length;
  assign bus.o_prgmem_in   = r_wr_en;
  assign bus.o_prgmem_addr = r_wr_addr;
  assign bus.o_prgmem_data = r_wr_data;

endmodule
`default_nettype wire

// File: tb/tb_bf_program_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_bf_program_loader
// Brief    : Self-checking bench for bf_program_loader; a source-level model
//            predicts the write list and final status of each program.
// Revision : 1.0  initial release
// ============================================================================
module tb_bf_program_loader;

  typedef logic [7:0] u8_t;

  logic i_clock = 1'b0;
  logic i_reset = 1'b1;

  bf_program_loader_if #(.PRGMEM_ADDR_WIDTH(8)) bus ();

  bf_program_loader #(.PRGMEM_ADDR_WIDTH(8), .MAX_NEST(16)) dut (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .bus     (bus)
  );

  always #5 i_clock = ~i_clock;

  int  pass_cnt = 0;
  int  total_cnt = 0;
  bit  chk_en = 1'b0;
  u8_t prog[$];
  int  exp_addr[$];
  int  exp_data[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Instruction code for a source character, -1 if it is not a command
  function automatic int enc(input u8_t c);
    case (c)
      "+":     return 3;
      "-":     return 2;
      ">":     return 5;
      "<":     return 4;
      "[":     return 7;
      "]":     return 6;
      default: return -1;
    endcase
  endfunction

  // Walk the source text, producing the expected write list and final status
  function automatic void model(output int err, output int len, output int stop);
    int depth = 0;
    err  = 0;
    len  = 0;
    stop = prog.size() - 1;
    exp_addr.delete();
    exp_data.delete();
    for (int i = 0; i < prog.size(); i++) begin
      int code = enc(prog[i]);
      if (prog[i] == 8'h00) begin
        if (depth != 0) err = 2;
        else for (int a = len; a < 256; a++) begin exp_addr.push_back(a); exp_data.push_back(0); end
        stop = i;
        return;
      end
      if (code < 0) continue;
      if (code == 6 && depth == 0) begin err = 1; stop = i; return; end
      if ((code == 7 && depth == 16) || len == 256) begin err = 3; stop = i; return; end
      exp_addr.push_back(len);
      exp_data.push_back(code);
      len++;
      if (code == 7) depth++;
      if (code == 6) depth--;
    end
  endfunction

  function automatic void put_str(input string s);
    for (int i = 0; i < s.len(); i++) prog.push_back(s[i]);
  endfunction

  // Every cycle: each write must be the next predicted one; status flags stay exclusive
  always @(negedge i_clock) begin
    if (chk_en) begin
      if (bus.o_prgmem_in) begin
        chk("extra_write", exp_addr.size() == 0, 0);
        if (exp_addr.size() != 0) begin
          chk("wr_addr", bus.o_prgmem_addr, exp_addr[0]);
          chk("wr_data", bus.o_prgmem_data, exp_data[0]);
          void'(exp_addr.pop_front());
          void'(exp_data.pop_front());
        end
      end
      chk("busy_done_excl", bus.o_busy & bus.o_done, 0);
      chk("error_quiet", (bus.o_error != 0) && (bus.o_busy || bus.o_done), 0);
    end
  end

  task automatic start_load();
    bus.i_start = 1'b1;
    @(negedge i_clock);
    bus.i_start = 1'b0;
    chk("busy_after_start", bus.o_busy, 1);
  endtask

  task automatic send(input u8_t b, input int gap);
    int n = 0;
    repeat (gap) begin bus.i_valid = 1'b0; @(negedge i_clock); end
    bus.i_valid = 1'b1;
    bus.i_data  = b;
    while (!bus.o_ready && n < 50) begin @(negedge i_clock); n++; end
    chk("ready_timeout", n < 50, 1);
    @(negedge i_clock);
    bus.i_valid = 1'b0;
  endtask

  task automatic run_prog(input int maxgap);
    int err, len, stop, n;
    model(err, len, stop);
    start_load();
    for (int i = 0; i <= stop; i++)
      send(prog[i], (maxgap == 0) ? 0 : int'($urandom_range(0, maxgap)));
    n = 0;
    while (!(bus.o_done || bus.o_error != 0) && n < 1000) begin @(negedge i_clock); n++; end
    chk("end_timeout", n < 1000, 1);
    repeat (2) @(negedge i_clock);
    chk("writes_left", exp_addr.size(), 0);
    chk("error", bus.o_error, err);
    chk("length", bus.o_length, len);
    chk("done", bus.o_done, err == 0);
    chk("busy_end", bus.o_busy, 0);
    chk("ready_end", bus.o_ready, 0);
  endtask

  initial begin
    int    err, len, stop, n;
    string alpha = "++--<>[[]].a \n";

    // Reset held together with start and valid: reset must win
    bus.i_start = 1'b1;
    bus.i_valid = 1'b1;
    bus.i_data  = "+";
    repeat (3) @(negedge i_clock);
    bus.i_start = 1'b0;
    bus.i_valid = 1'b0;
    i_reset     = 1'b0;
    chk("rst_busy",   bus.o_busy, 0);
    chk("rst_done",   bus.o_done, 0);
    chk("rst_error",  bus.o_error, 0);
    chk("rst_length", bus.o_length, 0);
    chk("rst_ready",  bus.o_ready, 0);
    chk("rst_wr",     bus.o_prgmem_in, 0);
    chk("rst_addr",   bus.o_prgmem_addr, 0);
    chk_en = 1'b1;

    // Pin the model on the reference loop program
    prog.delete(); put_str("+[->+<]"); prog.push_back(8'h00);
    model(err, len, stop);
    chk("model_nwrites", exp_addr.size(), 256);
    chk("model_c0", exp_data[0], 3);
    chk("model_c1", exp_data[1], 7);
    chk("model_c2", exp_data[2], 2);
    chk("model_c3", exp_data[3], 5);
    chk("model_c4", exp_data[4], 3);
    chk("model_c5", exp_data[5], 4);
    chk("model_c6", exp_data[6], 6);
    chk("model_fill7", exp_data[7], 0);
    run_prog(0);
    chk("loop_len_lit", bus.o_length, 7);
    chk("loop_done_lit", bus.o_done, 1);
    run_prog(3);  // same program with random valid gaps

    prog.delete(); put_str("a+ .\n-"); prog.push_back(8'h00);
    run_prog(2);
    chk("junk_len_lit", bus.o_length, 2);

    prog.delete(); put_str("]");
    run_prog(0);
    chk("unmatch_err_lit", bus.o_error, 1);
    chk("unmatch_ready_lit", bus.o_ready, 0);

    prog.delete(); put_str("[["); prog.push_back(8'h00);
    run_prog(0);
    chk("unclosed_err_lit", bus.o_error, 2);

    prog.delete(); repeat (17) prog.push_back("[");
    run_prog(1);
    chk("nest_err_lit", bus.o_error, 3);
    chk("nest_len_lit", bus.o_length, 16);

    prog.delete(); repeat (256) prog.push_back("+"); prog.push_back(8'h00);
    run_prog(0);
    chk("full_len_lit", bus.o_length, 256);

    prog.delete(); repeat (257) prog.push_back("+");
    run_prog(0);
    chk("overflow_err_lit", bus.o_error, 3);

    // Reset while filling address 100
    prog.delete(); repeat (10) prog.push_back("+"); prog.push_back(8'h00);
    model(err, len, stop);
    start_load();
    for (int i = 0; i <= stop; i++) send(prog[i], 0);
    n = 0;
    while (!(bus.o_prgmem_in && bus.o_prgmem_addr == 8'd100) && n < 500) begin
      @(negedge i_clock); n++;
    end
    chk("fill_reach_100", n < 500, 1);
    chk_en  = 1'b0;
    i_reset = 1'b1;
    @(negedge i_clock);
    i_reset = 1'b0;
    chk("midfill_wr",     bus.o_prgmem_in, 0);
    chk("midfill_busy",   bus.o_busy, 0);
    chk("midfill_length", bus.o_length, 0);
    chk("midfill_done",   bus.o_done, 0);
    exp_addr.delete();
    exp_data.delete();
    chk_en = 1'b1;

    prog.delete(); put_str("+"); prog.push_back(8'h00);
    run_prog(0);

    // Random programs, alternately gap-free and with gaps
    for (int r = 0; r < 10; r++) begin
      int plen = int'($urandom_range(3, 30));
      prog.delete();
      for (int k = 0; k < plen; k++) prog.push_back(alpha[$urandom_range(0, alpha.len() - 1)]);
      prog.push_back(8'h00);
      run_prog(r % 2 == 0 ? 0 : 3);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire
